// File: rtl/freg_wb_sched.sv
// Floating-point register file write-port scheduler: arbitrates FPU, LSU and
// JTAG writebacks onto one registered write port and tracks pending writes.
module freg_wb_sched #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid_i,
    input  logic [ADDR_W-1:0]   issue_rd_i,
    input  logic [ADDR_W-1:0]   issue_rs1_i,
    input  logic [ADDR_W-1:0]   issue_rs2_i,
    output logic                issue_stall_o,
    input  logic                fpu_valid_i,
    output logic                fpu_ready_o,
    input  logic [ADDR_W-1:0]   fpu_rd_i,
    input  logic [DATA_W-1:0]   fpu_data_i,
    input  logic                lsu_valid_i,
    output logic                lsu_ready_o,
    input  logic [ADDR_W-1:0]   lsu_rd_i,
    input  logic [DATA_W-1:0]   lsu_data_i,
    input  logic                jtag_valid_i,
    output logic                jtag_ready_o,
    input  logic [ADDR_W-1:0]   jtag_addr_i,
    input  logic [DATA_W-1:0]   jtag_data_i,
    output logic                we_o,
    output logic [ADDR_W-1:0]   waddr_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [REG_NUM-1:0]  busy_o,
    output logic                err_o
);

    typedef enum logic {FAV_FPU, FAV_LSU} rr_t;

    rr_t                rr_q, rr_d;
    logic               sb_write;   // current port write came from FPU/LSU and retires a busy bit
    logic [REG_NUM-1:0] busy_d;
    logic [REG_NUM-1:0] write_mask;
    logic [REG_NUM-1:0] eff_busy;
    logic               wb_to_idle;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        fpu_ready_o  = 1'b0;
        lsu_ready_o  = 1'b0;
        jtag_ready_o = 1'b0;
        rr_d         = rr_q;
        if (lsu_valid_i && (!fpu_valid_i || rr_q == FAV_LSU)) begin
            lsu_ready_o = 1'b1;
            rr_d        = FAV_FPU;
        end else if (fpu_valid_i) begin
            fpu_ready_o = 1'b1;
            rr_d        = FAV_LSU;
        end else if (jtag_valid_i && busy_o == '0) begin
            jtag_ready_o = 1'b1;
        end
    end

    // A register written this cycle is forwarded by the file, so it no longer blocks ID.
    always_comb begin
        write_mask = '0;
        if (we_o) write_mask[waddr_o] = 1'b1;
        eff_busy      = busy_o & ~write_mask;
        issue_stall_o = eff_busy[issue_rs1_i] | eff_busy[issue_rs2_i]
                      | (issue_valid_i & eff_busy[issue_rd_i]);
    end

    // Set after clear so a same-cycle issue to the retiring register keeps it busy.
    always_comb begin
        busy_d = busy_o;
        if (we_o && sb_write) busy_d[waddr_o] = 1'b0;
        if (issue_valid_i && !issue_stall_o) busy_d[issue_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    assign wb_to_idle = (fpu_ready_o && !busy_o[fpu_rd_i])
                      || (lsu_ready_o && !busy_o[lsu_rd_i]);

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q     <= FAV_LSU;
            we_o     <= 1'b0;
            waddr_o  <= '0;
            wdata_o  <= '0;
            sb_write <= 1'b0;
            busy_o   <= '0;
            err_o    <= 1'b0;
        end else begin
            rr_q     <= rr_d;
            we_o     <= fpu_ready_o | lsu_ready_o | jtag_ready_o;
            sb_write <= fpu_ready_o | lsu_ready_o;
            busy_o   <= busy_d;
            err_o    <= err_o | wb_to_idle;
            if (lsu_ready_o) begin
                waddr_o <= lsu_rd_i;
                wdata_o <= lsu_data_i;
            end else if (fpu_ready_o) begin
                waddr_o <= fpu_rd_i;
                wdata_o <= fpu_data_i;
            end else if (jtag_ready_o) begin
                waddr_o <= jtag_addr_i;
                wdata_o <= jtag_data_i;
            end
        end
    end

endmodule

// File: tb/tb_freg_wb_sched.sv
// Directed bench for freg_wb_sched: expected port writes go into a queue that a
// negedge monitor drains; handshake, busy, stall and err are checked inline.
module tb_freg_wb_sched;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int REG_NUM = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               issue_valid;
    logic [ADDR_W-1:0]  issue_rd, issue_rs1, issue_rs2;
    logic               issue_stall;
    logic               fpu_valid, fpu_ready;
    logic [ADDR_W-1:0]  fpu_rd;
    logic [DATA_W-1:0]  fpu_data;
    logic               lsu_valid, lsu_ready;
    logic [ADDR_W-1:0]  lsu_rd;
    logic [DATA_W-1:0]  lsu_data;
    logic               jtag_valid, jtag_ready;
    logic [ADDR_W-1:0]  jtag_addr;
    logic [DATA_W-1:0]  jtag_data;
    logic               we;
    logic [ADDR_W-1:0]  waddr;
    logic [DATA_W-1:0]  wdata;
    logic [REG_NUM-1:0] busy;
    logic               err;

    int  total = 0;
    int  bad   = 0;
    bit  mon_en = 1'b0;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    freg_wb_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_NUM(REG_NUM)) dut (
        .clk(clk), .rst(rst),
        .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
        .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2), .issue_stall_o(issue_stall),
        .fpu_valid_i(fpu_valid), .fpu_ready_o(fpu_ready), .fpu_rd_i(fpu_rd), .fpu_data_i(fpu_data),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_rd_i(lsu_rd), .lsu_data_i(lsu_data),
        .jtag_valid_i(jtag_valid), .jtag_ready_o(jtag_ready),
        .jtag_addr_i(jtag_addr), .jtag_data_i(jtag_data),
        .we_o(we), .waddr_o(waddr), .wdata_o(wdata), .busy_o(busy), .err_o(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
        fpu_valid   = 1'b0; fpu_rd = '0; fpu_data = '0;
        lsu_valid   = 1'b0; lsu_rd = '0; lsu_data = '0;
        jtag_valid  = 1'b0; jtag_addr = '0; jtag_data = '0;
        step();
        step();
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    // Monitor: every cycle the port writes, the oldest expected write must match.
    always @(negedge clk) begin
        if (mon_en && we === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL port_write: unexpected write addr=%0d data=0x%08h", waddr, wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (waddr !== e.addr || wdata !== e.data) begin
                    bad++;
                    $display("FAIL port_write: got addr=%0d data=0x%08h want addr=%0d data=0x%08h",
                             waddr, wdata, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and a single FPU writeback retiring an issued register
        do_reset();
        at_neg();
        check("rst_we", 32'(we), 32'd0);
        check("rst_waddr", 32'(waddr), 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_readies", {29'd0, fpu_ready, lsu_ready, jtag_ready}, 32'd0);
        step();
        issue_valid = 1'b1; issue_rd = 5'd3;
        at_neg();
        check("t1_issue_stall", 32'(issue_stall), 32'd0);
        step();
        issue_valid = 1'b0;
        fpu_valid = 1'b1; fpu_rd = 5'd3; fpu_data = 32'h3F80_0000;
        at_neg();
        check("t1_busy_set", busy, 32'h0000_0008);
        check("t1_fpu_ready", 32'(fpu_ready), 32'd1);
        check("t1_lsu_ready", 32'(lsu_ready), 32'd0);
        expect_write(5'd3, 32'h3F80_0000);
        step();
        fpu_valid = 1'b0;
        at_neg();
        check("t1_we", 32'(we), 32'd1);
        check("t1_busy_during_we", busy, 32'h0000_0008);
        step();
        at_neg();
        check("t1_busy_cleared", busy, 32'd0);
        check("t1_we_done", 32'(we), 32'd0);
        check("t1_err", 32'(err), 32'd0);

        // Round robin with both sources held: LSU, FPU, LSU, FPU
        do_reset();
        lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h1111_1111;
        fpu_valid = 1'b1; fpu_rd = 5'd5; fpu_data = 32'h2222_2222;
        for (int i = 0; i < 4; i++) begin
            logic exp_lsu;
            exp_lsu = (i % 2 == 0);
            at_neg();
            check("t2_lsu_ready", 32'(lsu_ready), 32'(exp_lsu));
            check("t2_fpu_ready", 32'(fpu_ready), 32'(!exp_lsu));
            if (i > 0) check("t2_we_stream", 32'(we), 32'd1);
            if (exp_lsu) expect_write(5'd6, 32'h1111_1111);
            else         expect_write(5'd5, 32'h2222_2222);
            step();
        end
        lsu_valid = 1'b0; fpu_valid = 1'b0;
        at_neg();
        check("t2_we_last", 32'(we), 32'd1);
        step();
        at_neg();
        check("t2_we_idle", 32'(we), 32'd0);

        // RAW stall, forwarding bypass, and set-wins on the retiring register
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd7;
        at_neg();
        step();
        issue_valid = 1'b0; issue_rs1 = 5'd7;
        at_neg();
        check("t3_raw_stall", 32'(issue_stall), 32'd1);
        step();
        fpu_valid = 1'b1; fpu_rd = 5'd7; fpu_data = 32'hC0A0_0000;
        at_neg();
        check("t3_fpu_ready", 32'(fpu_ready), 32'd1);
        check("t3_stall_at_xfer", 32'(issue_stall), 32'd1);
        expect_write(5'd7, 32'hC0A0_0000);
        step();
        fpu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        at_neg();
        check("t3_stall_bypass", 32'(issue_stall), 32'd0);
        step();
        issue_valid = 1'b0; issue_rs1 = 5'd0;
        at_neg();
        check("t3_set_wins", busy, 32'h0000_0080);
        check("t3_err", 32'(err), 32'd0);

        // JTAG waits for a quiescent file, then writes without touching busy
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd4;
        at_neg();
        step();
        issue_valid = 1'b0;
        jtag_valid = 1'b1; jtag_addr = 5'd2; jtag_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check("t4_jtag_blocked", 32'(jtag_ready), 32'd0);
            step();
        end
        fpu_valid = 1'b1; fpu_rd = 5'd4; fpu_data = 32'h4080_0000;
        at_neg();
        check("t4_fpu_ready", 32'(fpu_ready), 32'd1);
        check("t4_jtag_vs_fpu", 32'(jtag_ready), 32'd0);
        expect_write(5'd4, 32'h4080_0000);
        step();
        fpu_valid = 1'b0;
        at_neg();
        check("t4_jtag_busy_we", 32'(jtag_ready), 32'd0);
        step();
        at_neg();
        check("t4_busy_clear", busy, 32'd0);
        check("t4_jtag_grant", 32'(jtag_ready), 32'd1);
        expect_write(5'd2, 32'hDEAD_BEEF);
        step();
        jtag_valid = 1'b0;
        at_neg();
        check("t4_jtag_we", 32'(we), 32'd1);
        check("t4_busy_untouched", busy, 32'd0);
        step();
        at_neg();
        check("t4_err", 32'(err), 32'd0);

        // LSU writeback to an idle register: write still happens, err is sticky
        do_reset();
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h1234_5678;
        at_neg();
        check("t5_lsu_ready", 32'(lsu_ready), 32'd1);
        check("t5_err_before", 32'(err), 32'd0);
        expect_write(5'd9, 32'h1234_5678);
        step();
        lsu_valid = 1'b0;
        at_neg();
        check("t5_we", 32'(we), 32'd1);
        check("t5_err_set", 32'(err), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            at_neg();
            check("t5_err_sticky", 32'(err), 32'd1);
        end

        // Reset mid-write clears the port, busy bits and err
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd4;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'hAAAA_5555;
        at_neg();
        expect_write(5'd9, 32'hAAAA_5555);
        step();
        issue_rd = 5'd8;
        lsu_valid = 1'b0;
        at_neg();
        step();
        issue_valid = 1'b0;
        fpu_valid = 1'b1; fpu_rd = 5'd4; fpu_data = 32'h0000_0055;
        at_neg();
        check("t6_busy_pre", busy, 32'h0000_0110);
        check("t6_err_pre", 32'(err), 32'd1);
        expect_write(5'd4, 32'h0000_0055);
        step();
        fpu_valid = 1'b0;
        rst = 1'b1;
        at_neg();
        check("t6_we_at_rst", 32'(we), 32'd1);
        check("t6_busy_at_rst", busy, 32'h0000_0110);
        step();
        at_neg();
        check("t6_we_after_rst", 32'(we), 32'd0);
        check("t6_busy_after_rst", busy, 32'd0);
        check("t6_err_after_rst", 32'(err), 32'd0);
        rst = 1'b0;
        step();
        at_neg();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
